// File: rtl/clock_gate_pkg.sv
// Shared types and helpers for the latch-based clock gate slice.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_ON    = 2'd1,
    CG_DRAIN = 2'd2
  } cg_state_e;

  // Hold-off counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned holdoff);
    return (holdoff == 0) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/clock_gate_cell.sv
// Single glitch-free ICG: low-transparent enable latch ANDed with clk.
// Defining CLK_GATE_BYPASS_EN removes the latch and passes clk straight through.
module clock_gate_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic gclk_o
);

`ifdef CLK_GATE_BYPASS_EN
  logic unused_inputs;
  assign unused_inputs = rst_n ^ en_i;
  assign gclk_o        = clk;
`else
  logic en_lat;

  // Latch only follows en_i while clk is low, so the high phase is never cut short.
  always_latch begin
    if (!rst_n) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en_i;
    end
  end

  assign gclk_o = clk & en_lat;
`endif

endmodule

// File: rtl/latch_clock_gate.sv
// Multi-channel clock gate with test override and per-channel drain hold-off.
// Macro CLK_GATE_BYPASS_EN (in clock_gate_cell) replaces the gates with clk for FPGA emulation.
module latch_clock_gate
  import clock_gate_pkg::*;
#(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned HOLDOFF_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] gclk_o,
  output logic [NUM_CH-1:0] active_o
);

  localparam int unsigned   CW   = cnt_width(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] HOLD = CW'(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    cg_state_e     state_q, state_d;
    logic          active_q;
    logic          req;

    always_comb begin
      cnt_d = cnt_q;
      if (en_i[c]) begin
        cnt_d = HOLD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - ONE;
      end
    end

    // cnt <= 1 also covers HOLDOFF_CYCLES=1, where DRAIN is entered with cnt already 0.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        CG_OFF: begin
          if (en_i[c]) state_d = CG_ON;
        end
        CG_ON: begin
          if (!en_i[c]) state_d = (HOLDOFF_CYCLES > 0) ? CG_DRAIN : CG_OFF;
        end
        CG_DRAIN: begin
          if (en_i[c]) begin
            state_d = CG_ON;
          end else if (cnt_q <= ONE) begin
            state_d = CG_OFF;
          end
        end
        default: state_d = CG_OFF;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        state_q  <= CG_OFF;
        active_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        state_q  <= state_d;
        active_q <= (state_q != CG_OFF) | test_en_i;
      end
    end

    assign req         = en_i[c] | test_en_i | (cnt_q != '0);
    assign active_o[c] = active_q;

    clock_gate_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (req),
      .gclk_o (gclk_o[c])
    );
  end

endmodule

// File: tb/tb_latch_clock_gate.sv
// Randomised bench for latch_clock_gate: two instances (hold-off 3 and 0) against a reference model.
`timescale 1ns/1ps
module tb_latch_clock_gate;

  localparam int unsigned NCH   = 2;
  localparam int          HA    = 3;
  localparam int          HB    = 0;
  localparam int          NEVER = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           test_en_i = 1'b0;
  logic [NCH-1:0] en_i = '0;
  logic [NCH-1:0] gclk_a, gclk_b, act_a, act_b;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  latch_clock_gate #(.NUM_CH(NCH), .HOLDOFF_CYCLES(HA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
    .gclk_o(gclk_a), .active_o(act_a)
  );

  latch_clock_gate #(.NUM_CH(NCH), .HOLDOFF_CYCLES(HB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
    .gclk_o(gclk_b), .active_o(act_b)
  );

  int pa0 = 0, pa1 = 0, pb0 = 0, pb1 = 0;
  always @(posedge gclk_a[0]) pa0++;
  always @(posedge gclk_a[1]) pa1++;
  always @(posedge gclk_b[0]) pb0++;
  always @(posedge gclk_b[1]) pb1++;

  task automatic check(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Reference model: edges since en was last sampled high decide drain and state.
  int             since [2][NCH];
  bit             st_on [2][NCH];
  logic [NCH-1:0] exp_p [2];
  logic [NCH-1:0] exp_act [2];
  logic           m_rs, m_te;
  logic [NCH-1:0] m_en;
  int             m_h, m_lim;

  function automatic logic [NCH-1:0] exp_gclk(input logic [NCH-1:0] p);
`ifdef CLK_GATE_BYPASS_EN
    return '1;
`else
    return p & {NCH{rst_n}};
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_rs = rst_n;
      m_te = test_en_i;
      m_en = en_i;
      for (int d = 0; d < 2; d++) begin
        m_h   = (d == 0) ? HA : HB;
        m_lim = (m_h > 1) ? m_h - 1 : 1;
        for (int c = 0; c < NCH; c++) begin
          if (!m_rs) begin
            since[d][c]   = NEVER;
            st_on[d][c]   = 1'b0;
            exp_p[d][c]   = 1'b0;
            exp_act[d][c] = 1'b0;
          end else begin
            exp_p[d][c]   = m_en[c] | m_te | (since[d][c] < m_h);
            exp_act[d][c] = st_on[d][c] | m_te;
            since[d][c]   = m_en[c] ? 0 : ((since[d][c] >= NEVER) ? NEVER : since[d][c] + 1);
            st_on[d][c]   = m_en[c] || (m_h > 0 && since[d][c] >= 1 && since[d][c] <= m_lim);
          end
        end
      end
      #2;
      check("gclk_a_hi", gclk_a, exp_gclk(exp_p[0]));
      check("gclk_b_hi", gclk_b, exp_gclk(exp_p[1]));
      check("active_a", act_a, exp_act[0]);
      check("active_b", act_b, exp_act[1]);
      #3;
      check("gclk_a_mid", gclk_a, exp_gclk(exp_p[0]));
      check("gclk_b_mid", gclk_b, exp_gclk(exp_p[1]));
      #3;
      check("gclk_a_late", gclk_a, exp_gclk(exp_p[0]));
      check("gclk_b_late", gclk_b, exp_gclk(exp_p[1]));
      #7;
      check("gclk_a_lo", gclk_a, '0);
      check("gclk_b_lo", gclk_b, '0);
    end
  end

  // Drive in the low phase; optional input glitches strictly inside the high phase.
  task automatic cyc(input logic [NCH-1:0] en, input logic te,
                     input logic [NCH-1:0] gmask, input logic tmask);
    @(negedge clk);
    en_i      = en;
    test_en_i = te;
    @(posedge clk);
    #4;
    en_i      = en_i ^ gmask;
    test_en_i = test_en_i ^ tmask;
    #2;
    en_i      = en_i ^ gmask;
    test_en_i = test_en_i ^ tmask;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #4 rst_n = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  int             b_pa0, b_pa1, b_pb0, b_pb1, n_act_a, n_act_b;
  logic [NCH-1:0] en_r;
  logic           te_r, tm_r;
  logic [NCH-1:0] gm_r;

  initial begin
    @(posedge clk);
    #4 rst_n = 1'b1;
    cyc('0, 1'b0, '0, 1'b0);
    cyc('0, 1'b0, '0, 1'b0);

    // en_i[0] high for two edges, with glitches injected on idle/draining phases.
    b_pa0 = pa0; b_pa1 = pa1; b_pb0 = pb0; b_pb1 = pb1;
    n_act_a = 0; n_act_b = 0;
    for (int i = 0; i < 10; i++) begin
      cyc((i < 2) ? 2'b01 : 2'b00, 1'b0, (i == 3 || i == 6) ? 2'b11 : 2'b00, 1'b0);
      n_act_a += int'(act_a[0]);
      n_act_b += int'(act_b[0]);
    end
`ifdef CLK_GATE_BYPASS_EN
    check_int("pulses_a0", pa0 - b_pa0, 10);
    check_int("pulses_a1", pa1 - b_pa1, 10);
    check_int("pulses_b0", pb0 - b_pb0, 10);
    check_int("pulses_b1", pb1 - b_pb1, 10);
`else
    check_int("pulses_a0", pa0 - b_pa0, 5);
    check_int("pulses_a1", pa1 - b_pa1, 0);
    check_int("pulses_b0", pb0 - b_pb0, 2);
    check_int("pulses_b1", pb1 - b_pb1, 0);
`endif
    check_int("active_cycles_a0", n_act_a, 4);
    check_int("active_cycles_b0", n_act_b, 2);

    // Test override with functional enables low.
    cyc('0, 1'b1, '0, 1'b0);
    cyc('0, 1'b1, '0, 1'b0);
    check("test_active_a", act_a, 2'b11);
    check("test_active_b", act_b, 2'b11);
    cyc('0, 1'b1, '0, 1'b0);
    cyc('0, 1'b0, '0, 1'b0);
    cyc('0, 1'b0, '0, 1'b0);

    // Reset hit while running under test override, released mid-high.
    cyc(2'b11, 1'b1, '0, 1'b0);
    cyc(2'b11, 1'b1, '0, 1'b0);
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
`ifndef CLK_GATE_BYPASS_EN
    check("rst_gclk_a", gclk_a, 2'b00);
    check("rst_gclk_b", gclk_b, 2'b00);
`endif
    check("rst_active_a", act_a, 2'b00);
    check("rst_active_b", act_b, 2'b00);
    @(negedge clk);
    en_i      = 2'b01;
    test_en_i = 1'b0;
    @(posedge clk);
    #4 rst_n = 1'b1;
    b_pa0 = pa0;
    cyc(2'b01, 1'b0, '0, 1'b0);
    cyc(2'b00, 1'b0, '0, 1'b0);
    cyc(2'b00, 1'b0, '0, 1'b0);
`ifndef CLK_GATE_BYPASS_EN
    check_int("post_rst_pulses_a0", pa0 - b_pa0, 3);
`endif

    en_r = '0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_pulse();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 3) == 0) en_r[c] = ~en_r[c];
        end
        te_r = ($urandom_range(0, 11) == 0);
        gm_r = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
        tm_r = ($urandom_range(0, 7) == 0);
        cyc(en_r, te_r, gm_r, tm_r);
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
